// File: rtl/branch_resolver.sv
// branch_resolver: branch-outcome resolution, 2-bit saturating direction
// table with a one-cycle fetch query port, mispredict/illegal-funct3 pulses
// and saturating statistics counters.
module branch_resolver #(
   parameter int unsigned IDX_BITS = 4,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic             is_branch,
   input  logic [2:0]       funct3,
   input  logic [31:0]      pc,
   input  logic             pred_in,
   input  logic             BrEq,
   input  logic             BrLT,
   output logic             BrUn,
   output logic             taken,
   input  logic             q_valid,
   input  logic [31:0]      q_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic             mispredict,
   output logic             illegal_f3,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mis_count
);

   localparam int unsigned ENTRIES = 1 << IDX_BITS;

   logic [1:0]          r_tbl [ENTRIES];
   logic                r_pred_valid;
   logic                r_pred_taken;
   logic                r_mispredict;
   logic                r_illegal_f3;
   logic [CNT_W-1:0]    r_br_count;
   logic [CNT_W-1:0]    r_mis_count;

   logic                w_res;
   logic                w_legal;
   logic                w_upd;
   logic                w_cond;
   logic                w_mis_evt;
   logic [IDX_BITS-1:0] w_upd_idx;
   logic [IDX_BITS-1:0] w_q_idx;
   logic [1:0]          w_cur;
   logic [1:0]          w_next;
   logic [1:0]          w_q_entry;
   logic                w_unused;

   // Unsigned select comes straight from funct3, independent of valid
   assign BrUn      = funct3[1];

   assign w_res     = valid & is_branch;
   assign w_legal   = (funct3[2:1] != 2'b01);
   assign w_upd     = w_res & w_legal;
   assign taken     = w_upd & w_cond;
   assign w_mis_evt = w_upd & (w_cond != pred_in);

   assign w_upd_idx = pc[IDX_BITS+1:2];
   assign w_q_idx   = q_pc[IDX_BITS+1:2];
   assign w_cur     = r_tbl[w_upd_idx];

   // Bits outside the index field carry no information (no tags)
   assign w_unused  = ^{pc[31:IDX_BITS+2], pc[1:0], q_pc[31:IDX_BITS+2], q_pc[1:0]};

   // Branch condition decode from comparator flags
   always_comb begin
      w_cond = 1'b0;
      case (funct3)
         3'b000:         w_cond = BrEq;
         3'b001:         w_cond = ~BrEq;
         3'b100, 3'b110: w_cond = BrLT;
         3'b101, 3'b111: w_cond = ~BrLT;
         default:        w_cond = 1'b0;
      endcase
   end

   // Saturating step of the resolving entry
   always_comb begin
      w_next = w_cur;
      if (w_cond) begin
         if (w_cur != 2'b11) w_next = w_cur + 2'd1;
      end else begin
         if (w_cur != 2'b00) w_next = w_cur - 2'd1;
      end
   end

   // Query sees the same-cycle update when indices collide (write-first)
   always_comb begin
      w_q_entry = r_tbl[w_q_idx];
      if (w_upd && (w_q_idx == w_upd_idx)) w_q_entry = w_next;
   end

   // Direction table; every entry resets to weakly not taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= 2'b01;
      end else if (w_upd) begin
         r_tbl[w_upd_idx] <= w_next;
      end
   end

   // Registered query response and event pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_mispredict <= 1'b0;
         r_illegal_f3 <= 1'b0;
      end else begin
         r_pred_valid <= q_valid;
         r_pred_taken <= q_valid & w_q_entry[1];
         r_mispredict <= w_mis_evt;
         r_illegal_f3 <= w_res & ~w_legal;
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br_count  <= '0;
         r_mis_count <= '0;
      end else begin
         if (w_upd && !(&r_br_count))      r_br_count  <= r_br_count + CNT_W'(1);
         if (w_mis_evt && !(&r_mis_count)) r_mis_count <= r_mis_count + CNT_W'(1);
      end
   end

   assign pred_valid = r_pred_valid;
   assign pred_taken = r_pred_taken;
   assign mispredict = r_mispredict;
   assign illegal_f3 = r_illegal_f3;
   assign br_count   = r_br_count;
   assign mis_count  = r_mis_count;

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed vectors with hand-computed
// expectations, a scoreboard queue of next-cycle registered outputs and a
// negedge monitor that pops and compares.
module tb_branch_resolver;

   logic        clk;
   logic        rst;
   logic        valid;
   logic        is_branch;
   logic [2:0]  funct3;
   logic [31:0] pc;
   logic        pred_in;
   logic        BrEq;
   logic        BrLT;
   logic        BrUn;
   logic        taken;
   logic        q_valid;
   logic [31:0] q_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic        mispredict;
   logic        illegal_f3;
   logic [3:0]  br_count;
   logic [3:0]  mis_count;

   typedef struct packed {
      logic       pv;
      logic       pt;
      logic       mis;
      logic       ill;
      logic [3:0] br;
      logic [3:0] mc;
   } exp_t;

   exp_t       sb[$];
   int         n_chk  = 0;
   int         n_fail = 0;
   logic [3:0] exp_br = 4'd0;
   logic [3:0] exp_mis = 4'd0;

   branch_resolver #(.IDX_BITS(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .valid(valid), .is_branch(is_branch),
      .funct3(funct3), .pc(pc), .pred_in(pred_in), .BrEq(BrEq), .BrLT(BrLT),
      .BrUn(BrUn), .taken(taken), .q_valid(q_valid), .q_pc(q_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .mispredict(mispredict), .illegal_f3(illegal_f3),
      .br_count(br_count), .mis_count(mis_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: each cycle compare registered outputs with the queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("pred_valid", 32'(pred_valid), 32'(e.pv));
         if (e.pv) chk("pred_taken", 32'(pred_taken), 32'(e.pt));
         chk("mispredict", 32'(mispredict), 32'(e.mis));
         chk("illegal_f3", 32'(illegal_f3), 32'(e.ill));
         chk("br_count", 32'(br_count), 32'(e.br));
         chk("mis_count", 32'(mis_count), 32'(e.mc));
      end else begin
         chk("pred_valid_unexpected", 32'(pred_valid), 32'd0);
      end
   end

   // Drive one cycle of stimulus, check combinational outputs, queue registered ones
   task automatic vec(input logic v, input logic b, input logic [2:0] f,
                      input logic [31:0] p, input logic pin, input logic eq,
                      input logic lt, input logic qv, input logic [31:0] qp,
                      input logic e_brun, input logic e_tk, input logic e_pt,
                      input logic e_mis, input logic e_ill);
      exp_t e;
      valid = v; is_branch = b; funct3 = f; pc = p; pred_in = pin;
      BrEq = eq; BrLT = lt; q_valid = qv; q_pc = qp;
      #1;
      chk("BrUn", 32'(BrUn), 32'(e_brun));
      chk("taken", 32'(taken), 32'(e_tk));
      @(posedge clk);
      if (v && b && (f[2:1] != 2'b01) && exp_br != 4'hF) exp_br = exp_br + 4'd1;
      if (e_mis && exp_mis != 4'hF) exp_mis = exp_mis + 4'd1;
      e.pv = qv; e.pt = e_pt; e.mis = e_mis; e.ill = e_ill;
      e.br = exp_br; e.mc = exp_mis;
      sb.push_back(e);
      #1;
   endtask

   task automatic query(input logic [31:0] qp, input logic e_pt);
      vec(1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, qp, 1'b0, 1'b0, e_pt, 1'b0, 1'b0);
   endtask

   // Asynchronous reset between edges; outputs must clear immediately
   task automatic rst_mid();
      rst = 1'b1;
      #1;
      chk("rst_pred_valid", 32'(pred_valid), 32'd0);
      chk("rst_pred_taken", 32'(pred_taken), 32'd0);
      chk("rst_mispredict", 32'(mispredict), 32'd0);
      chk("rst_illegal_f3", 32'(illegal_f3), 32'd0);
      chk("rst_br_count", 32'(br_count), 32'd0);
      chk("rst_mis_count", 32'(mis_count), 32'd0);
      sb.delete();
      exp_br = 4'd0;
      exp_mis = 4'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; valid = 1'b0; is_branch = 1'b0; funct3 = 3'b000; pc = 32'h0;
      pred_in = 1'b0; BrEq = 1'b0; BrLT = 1'b0; q_valid = 1'b0; q_pc = 32'h0;
      #1;
      rst_mid();

      // Decode sweep at pc 0x40, pred_in=0 so every taken is a mispredict;
      // 18 legal branches also saturate the 4-bit br_count at 15
      vec(1,1,3'b000,32'h40,0,1,0,0,32'h0, 0,1,0,1,0);
      vec(1,1,3'b000,32'h40,0,0,1,0,32'h0, 0,0,0,0,0);
      vec(1,1,3'b000,32'h40,0,0,0,0,32'h0, 0,0,0,0,0);
      vec(1,1,3'b001,32'h40,0,1,0,0,32'h0, 0,0,0,0,0);
      vec(1,1,3'b001,32'h40,0,0,1,0,32'h0, 0,1,0,1,0);
      vec(1,1,3'b001,32'h40,0,0,0,0,32'h0, 0,1,0,1,0);
      vec(1,1,3'b100,32'h40,0,1,0,0,32'h0, 0,0,0,0,0);
      vec(1,1,3'b100,32'h40,0,0,1,0,32'h0, 0,1,0,1,0);
      vec(1,1,3'b100,32'h40,0,0,0,0,32'h0, 0,0,0,0,0);
      vec(1,1,3'b101,32'h40,0,1,0,0,32'h0, 0,1,0,1,0);
      vec(1,1,3'b101,32'h40,0,0,1,0,32'h0, 0,0,0,0,0);
      vec(1,1,3'b101,32'h40,0,0,0,0,32'h0, 0,1,0,1,0);
      vec(1,1,3'b110,32'h40,0,1,0,0,32'h0, 1,0,0,0,0);
      vec(1,1,3'b110,32'h40,0,0,1,0,32'h0, 1,1,0,1,0);
      vec(1,1,3'b110,32'h40,0,0,0,0,32'h0, 1,0,0,0,0);
      vec(1,1,3'b111,32'h40,0,1,0,0,32'h0, 1,1,0,1,0);
      vec(1,1,3'b111,32'h40,0,0,1,0,32'h0, 1,0,0,0,0);
      vec(1,1,3'b111,32'h40,0,0,0,0,32'h0, 1,1,0,1,0);
      // Illegal funct3, not-valid and not-branch cases
      vec(1,1,3'b010,32'h40,1,1,1,0,32'h0, 1,0,0,0,1);
      vec(1,1,3'b011,32'h40,1,1,1,0,32'h0, 1,0,0,0,1);
      vec(0,1,3'b000,32'h40,1,1,0,0,32'h0, 0,0,0,0,0);
      vec(1,0,3'b001,32'h40,1,0,0,0,32'h0, 0,0,0,0,0);
      rst_mid();

      // Training at pc 0x10: 01->10->11->11
      vec(1,1,3'b000,32'h10,0,1,0,0,32'h0, 0,1,0,1,0);
      vec(1,1,3'b000,32'h10,0,1,0,0,32'h0, 0,1,0,1,0);
      vec(1,1,3'b000,32'h10,0,1,0,0,32'h0, 0,1,0,1,0);
      query(32'h10, 1'b1);
      query(32'h1050, 1'b1);
      // Not-taken with same-index query: 11->10 (pt=1), 10->01 (pt=0)
      vec(1,1,3'b000,32'h10,1,0,0,1,32'h10, 0,0,1,1,0);
      vec(1,1,3'b000,32'h10,1,0,0,1,32'h10, 0,0,0,1,0);
      // Write-first at pc 0x20: 01->10 seen by same-cycle query
      vec(1,1,3'b001,32'h20,1,0,0,1,32'h20, 0,1,1,0,0);
      query(32'h20, 1'b1);
      query(32'h10, 1'b0);
      rst_mid();

      // Stats: 4 legal branches, 2 mispredicts, then an illegal funct3
      vec(1,1,3'b100,32'h30,1,0,1,0,32'h0, 0,1,0,0,0);
      vec(1,1,3'b101,32'h30,1,0,1,0,32'h0, 0,0,0,1,0);
      vec(1,1,3'b110,32'h30,0,0,0,0,32'h0, 1,0,0,0,0);
      vec(1,1,3'b111,32'h30,0,0,0,0,32'h0, 1,1,0,1,0);
      vec(1,1,3'b010,32'h30,1,0,0,0,32'h0, 1,0,0,0,1);
      query(32'h30, 1'b0);

      // Retrain 0x10 to strongly taken, query, then reset with the answer pending
      vec(1,1,3'b000,32'h10,1,1,0,0,32'h0, 0,1,0,0,0);
      vec(1,1,3'b000,32'h10,1,1,0,0,32'h0, 0,1,0,0,0);
      query(32'h10, 1'b1);
      rst_mid();
      query(32'h10, 1'b0);
      vec(0,0,3'b000,32'h0,0,0,0,0,32'h0, 0,0,0,0,0);

      repeat (3) @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolve-side partner of the branch comparator: decodes the branch funct3 into the comparator's BrUn select, turns the returned BrEq/BrLT flags into a taken/not-taken decision, and keeps a direct-mapped table of 2-bit saturating counters that fetch queries for a next-cycle taken prediction. It also reports registered mispredict pulses and saturating statistics counters. It sits between decode/execute (comparator side) and the PC-select/fetch logic.

## Interface
- IDX_BITS, 4, table index width; table has 2^IDX_BITS entries indexed by pc[IDX_BITS+1:2]
- CNT_W, 32, width of statistics counters
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- valid  in  1  resolve-port instruction valid this cycle
- is_branch  in  1  resolve-port instruction is a conditional branch
- funct3  in  3  branch funct3 of the resolving instruction
- pc  in  32  PC of the resolving instruction
- pred_in  in  1  prediction previously used for this branch
- BrEq  in  1  equality flag from the comparator
- BrLT  in  1  less-than flag from the comparator
- BrUn  out  1  unsigned-compare select to the comparator
- taken  out  1  resolved branch outcome, combinational
- q_valid  in  1  fetch prediction query valid
- q_pc  in  32  fetch query PC
- pred_valid  out  1  registered; query answered this cycle
- pred_taken  out  1  registered; predicted direction
- mispredict  out  1  registered one-cycle pulse
- illegal_f3  out  1  registered one-cycle pulse for funct3 010/011
- br_count  out  CNT_W  legal branches resolved, saturating
- mis_count  out  CNT_W  mispredicts, saturating

## Operation
- BrUn = funct3[1] (1 for BLTU/BGEU, 0 otherwise), combinational, independent of valid.
- res = valid & is_branch; legal = funct3 not in {010, 011}.
- taken (0 unless res & legal): 000 BEQ -> BrEq; 001 BNE -> !BrEq; 100/110 BLT/BLTU -> BrLT; 101/111 BGE/BGEU -> !BrLT.
- Table update when res & legal: entry pc[IDX_BITS+1:2]; taken -> increment saturating at 11; not taken -> decrement saturating at 00.
- Illegal funct3 with res: no table update, no counter change, taken=0, illegal_f3 pulses next cycle.
- mispredict next cycle = res & legal & (taken != pred_in).
- br_count += 1 per res & legal; mis_count += 1 per mispredict event; both hold at all-ones.
- Query: pred_taken = bit[1] of entry q_pc[IDX_BITS+1:2]; pred_valid = q_valid, both registered.
- Same-cycle update and query to the same index: query returns the post-update value (write-first).
- pc/q_pc bits outside the index field are ignored (no tags; aliasing allowed).

## Timing
- Reset (asynchronous, immediate): every table entry = 01 (weakly not taken); pred_valid, pred_taken, mispredict, illegal_f3 = 0; br_count = mis_count = 0.
- BrUn and taken: zero-latency combinational from inputs.
- Query latency 1 cycle: q_valid at edge N -> pred_valid/pred_taken valid during cycle N+1, deasserted N+2 unless re-queried.
- mispredict, illegal_f3: asserted exactly the cycle after the resolving edge, single-cycle.
- Counters and table visible updated the cycle after the resolving edge.
- Back-to-back resolves to one entry every cycle accumulate: each edge applies one saturating step.
- Reset asserted mid-operation discards pending pulses and query results; first valid query after release sees 01 (pred_taken=0).

## Test plan
- Decode sweep: each legal funct3 with (BrEq,BrLT) in {(1,0),(0,1),(0,0)} -> BrUn = funct3[1]; taken matches map, e.g. 101 with BrLT=1 -> taken=0.
- Training: after reset, three taken resolves at pc=0x0000_0010 -> entry 01->10->11->11; query q_pc=0x0000_0010 -> pred_taken=1 next cycle; two not-taken -> 01, pred_taken=0.
- Write-first: same cycle resolve taken at pc=0x20 (entry 01) and query q_pc=0x20 -> pred_taken=1 next cycle.
- Mispredict/stats: 4 legal branches, 2 with pred_in != taken -> br_count=4, mis_count=2, mispredict pulses one cycle each; funct3=010 -> illegal_f3 pulse, counts unchanged.
- Saturation: CNT_W=4, 17 legal branches -> br_count stays 15.
- Async reset mid-run: assert rst between edges after training -> all outputs 0 immediately, subsequent query of trained PC -> pred_taken=0.
